// File: rtl/puf_uart_seq.sv
// UART command sequencer for the PUF core: decodes S/W/R opcodes and streams replies.
// Optional WAIT-state timeout is built when PUF_SEQ_TIMEOUT_EN is defined.
module puf_uart_seq #(
  parameter int unsigned       SEL_W       = 8,
  parameter int unsigned       WAIT_W      = 16,
  parameter logic [WAIT_W-1:0] WAIT_DEF    = 16'd100,
  parameter logic [23:0]       TIMEOUT_CYC = 24'd1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        uart_rx_data,
  input  logic              uart_rx_valid,
  input  logic              uart_tx_busy,
  output logic [SEL_W-1:0]  seq_tx_data,
  output logic              seq_tx_valid,
  output logic              puf_req_o,
  output logic [SEL_W-1:0]  puf_sel_o,
  output logic [WAIT_W-1:0] puf_wait_cyc_o,
  input  logic              puf_valid_i,
  input  logic              puf_done_i,
  input  logic              puf_busy_i,
  input  logic [5:0]        puf_q_i,
  input  logic [5:0]        puf_qn_i
);

  localparam logic [7:0] OpSel  = 8'h53;
  localparam logic [7:0] OpWait = 8'h57;
  localparam logic [7:0] OpRun  = 8'h52;
  localparam logic [7:0] RspOk  = 8'h4B;
  localparam logic [7:0] RspBad = 8'h3F;

  typedef enum logic [2:0] {StIdle, StArg, StReq, StWait, StSend, StHold} state_e;

  state_e              r_state, w_state;
  logic                r_is_w, w_is_w;
  logic                r_arg_cnt, w_arg_cnt;
  logic [7:0]          r_arg_hi, w_arg_hi;
  logic [SEL_W-1:0]    r_sel, w_sel;
  logic [WAIT_W-1:0]   r_wait, w_wait;
  logic [7:0]          r_rsp0, w_rsp0;
  logic [7:0]          r_rsp1, w_rsp1;
  logic                r_two, w_two;
  logic                r_guard, w_guard;
  logic [SEL_W-1:0]    r_tx_data, w_tx_data;
  logic                r_tx_valid, w_tx_valid;
  logic                r_req, w_req;

`ifdef PUF_SEQ_TIMEOUT_EN
  localparam logic [7:0] RspTmo = 8'h54;
  logic [23:0]         r_tmo_cnt, w_tmo_cnt;
`else
  logic [23:0]         w_unused_tmo;
  assign w_unused_tmo = TIMEOUT_CYC;
`endif

  always_comb begin
    w_state    = r_state;
    w_is_w     = r_is_w;
    w_arg_cnt  = r_arg_cnt;
    w_arg_hi   = r_arg_hi;
    w_sel      = r_sel;
    w_wait     = r_wait;
    w_rsp0     = r_rsp0;
    w_rsp1     = r_rsp1;
    w_two      = r_two;
    w_guard    = r_guard;
    w_tx_data  = r_tx_data;
    w_tx_valid = 1'b0;
    w_req      = 1'b0;
`ifdef PUF_SEQ_TIMEOUT_EN
    w_tmo_cnt  = r_tmo_cnt;
`endif
    unique case (r_state)
      StIdle: begin
        if (uart_rx_valid) begin
          case (uart_rx_data)
            OpSel:   begin w_state = StArg; w_is_w = 1'b0; w_arg_cnt = 1'b0; end
            OpWait:  begin w_state = StArg; w_is_w = 1'b1; w_arg_cnt = 1'b0; end
            OpRun:   w_state = StReq;
            default: begin w_rsp0 = RspBad; w_two = 1'b0; w_state = StSend; end
          endcase
        end
      end
      StArg: begin
        if (uart_rx_valid) begin
          if (!r_is_w) begin
            w_sel   = SEL_W'(uart_rx_data);
            w_rsp0  = RspOk;
            w_two   = 1'b0;
            w_state = StSend;
          end else if (!r_arg_cnt) begin
            w_arg_hi  = uart_rx_data;
            w_arg_cnt = 1'b1;
          end else begin
            w_wait  = WAIT_W'({r_arg_hi, uart_rx_data});
            w_rsp0  = RspOk;
            w_two   = 1'b0;
            w_state = StSend;
          end
        end
      end
      StReq: begin
        if (!puf_busy_i) begin
          w_req   = 1'b1;
          w_state = StWait;
`ifdef PUF_SEQ_TIMEOUT_EN
          w_tmo_cnt = 24'd0;
`endif
        end
      end
      StWait: begin
        if (puf_done_i) begin
          w_rsp0  = {puf_valid_i, 1'b0, puf_q_i};
          w_rsp1  = {2'b00, puf_qn_i};
          w_two   = 1'b1;
          w_state = StSend;
        end
`ifdef PUF_SEQ_TIMEOUT_EN
        else if (r_tmo_cnt == TIMEOUT_CYC - 24'd1) begin
          w_rsp0  = RspTmo;
          w_two   = 1'b0;
          w_state = StSend;
        end else begin
          w_tmo_cnt = r_tmo_cnt + 24'd1;
        end
`endif
      end
      StSend: begin
        if (!uart_tx_busy) begin
          w_tx_valid = 1'b1;
          w_tx_data  = SEL_W'(r_rsp0);
          w_guard    = 1'b1;
          w_state    = StHold;
        end
      end
      StHold: begin
        // First HOLD cycle ignores busy: the transmitter may not have raised it yet.
        if (r_guard) begin
          w_guard = 1'b0;
        end else if (!uart_tx_busy) begin
          if (r_two) begin
            w_rsp0  = r_rsp1;
            w_two   = 1'b0;
            w_state = StSend;
          end else begin
            w_state = StIdle;
          end
        end
      end
      default: w_state = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_is_w     <= 1'b0;
      r_arg_cnt  <= 1'b0;
      r_arg_hi   <= '0;
      r_sel      <= '0;
      r_wait     <= WAIT_DEF;
      r_rsp0     <= '0;
      r_rsp1     <= '0;
      r_two      <= 1'b0;
      r_guard    <= 1'b0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_req      <= 1'b0;
`ifdef PUF_SEQ_TIMEOUT_EN
      r_tmo_cnt  <= '0;
`endif
    end else begin
      r_state    <= w_state;
      r_is_w     <= w_is_w;
      r_arg_cnt  <= w_arg_cnt;
      r_arg_hi   <= w_arg_hi;
      r_sel      <= w_sel;
      r_wait     <= w_wait;
      r_rsp0     <= w_rsp0;
      r_rsp1     <= w_rsp1;
      r_two      <= w_two;
      r_guard    <= w_guard;
      r_tx_data  <= w_tx_data;
      r_tx_valid <= w_tx_valid;
      r_req      <= w_req;
`ifdef PUF_SEQ_TIMEOUT_EN
      r_tmo_cnt  <= w_tmo_cnt;
`endif
    end
  end

  assign seq_tx_data    = r_tx_data;
  assign seq_tx_valid   = r_tx_valid;
  assign puf_req_o      = r_req;
  assign puf_sel_o      = r_sel;
  assign puf_wait_cyc_o = r_wait;

endmodule

// File: tb/tb_puf_uart_seq.sv
// Directed bench for puf_uart_seq; timeout scenario runs only with PUF_SEQ_TIMEOUT_EN.
module tb_puf_uart_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  uart_rx_data;
  logic        uart_rx_valid;
  logic        uart_tx_busy;
  logic [7:0]  seq_tx_data;
  logic        seq_tx_valid;
  logic        puf_req_o;
  logic [7:0]  puf_sel_o;
  logic [15:0] puf_wait_cyc_o;
  logic        puf_valid_i, puf_done_i, puf_busy_i;
  logic [5:0]  puf_q_i, puf_qn_i;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int busy_len = 0;
  int busy_cnt = 0;
  bit busy_force = 1'b0;
  logic [7:0] tx_q[$];
  int tx_t[$];
  int req_t[$];

  puf_uart_seq #(.SEL_W(8), .WAIT_W(16), .WAIT_DEF(16'd100), .TIMEOUT_CYC(24'd20)) dut (
    .clk(clk), .rst(rst), .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid),
    .uart_tx_busy(uart_tx_busy), .seq_tx_data(seq_tx_data), .seq_tx_valid(seq_tx_valid),
    .puf_req_o(puf_req_o), .puf_sel_o(puf_sel_o), .puf_wait_cyc_o(puf_wait_cyc_o),
    .puf_valid_i(puf_valid_i), .puf_done_i(puf_done_i), .puf_busy_i(puf_busy_i),
    .puf_q_i(puf_q_i), .puf_qn_i(puf_qn_i)
  );

  always #5 clk = ~clk;

  // Monitor plus transmitter model: busy held busy_len cycles after each strobe.
  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    if (busy_cnt > 0) busy_cnt = busy_cnt - 1;
    if (seq_tx_valid) begin
      tx_q.push_back(seq_tx_data);
      tx_t.push_back(cyc);
      busy_cnt = busy_len;
    end
    if (puf_req_o) req_t.push_back(cyc);
    uart_tx_busy = (busy_cnt != 0) || busy_force;
  end

  task automatic send_byte(input logic [7:0] b, output int t0);
    @(negedge clk);
    t0 = cyc;
    uart_rx_data  = b;
    uart_rx_valid = 1'b1;
    @(negedge clk);
    uart_rx_valid = 1'b0;
  endtask

  task automatic wait_tx(input int n, input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      if (tx_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic clear_logs();
    tx_q.delete();
    tx_t.delete();
    req_t.delete();
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && busy_cnt != 0; i++) @(negedge clk);
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (puf_sel_o !== 8'h00) begin errors++; $display("FAIL reset_sel got %h want 00", puf_sel_o); end
    checks++; if (puf_wait_cyc_o !== 16'd100) begin errors++; $display("FAIL reset_wait got %0d want 100", puf_wait_cyc_o); end
    checks++; if (seq_tx_valid !== 1'b0) begin errors++; $display("FAIL reset_txv got %b want 0", seq_tx_valid); end
    checks++; if (puf_req_o !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", puf_req_o); end
    checks++; if (seq_tx_data !== 8'h00) begin errors++; $display("FAIL reset_txd got %h want 00", seq_tx_data); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_sel();
    int t, t1;
    bit ok;
    clear_logs();
    send_byte(8'h53, t);
    send_byte(8'hA5, t1);
    checks++; if (puf_sel_o !== 8'hA5) begin errors++; $display("FAIL sel_load got %h want a5", puf_sel_o); end
    wait_tx(1, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL sel_reply got none want 1 strobe"); end
    checks++; if (tx_q[0] !== 8'h4B) begin errors++; $display("FAIL sel_reply_data got %h want 4b", tx_q[0]); end
    checks++; if (tx_t[0] !== t1 + 2) begin errors++; $display("FAIL sel_reply_time got %0d want %0d", tx_t[0], t1 + 2); end
    drain();
    checks++; if (tx_q.size() !== 1) begin errors++; $display("FAIL sel_reply_count got %0d want 1", tx_q.size()); end
  endtask

  task automatic test_wait();
    int t, t1;
    bit ok;
    clear_logs();
    send_byte(8'h57, t);
    send_byte(8'h12, t);
    checks++; if (puf_wait_cyc_o !== 16'd100) begin errors++; $display("FAIL wait_partial got %h want 0064", puf_wait_cyc_o); end
    send_byte(8'h34, t1);
    checks++; if (puf_wait_cyc_o !== 16'h1234) begin errors++; $display("FAIL wait_load got %h want 1234", puf_wait_cyc_o); end
    wait_tx(1, 20, ok);
    checks++; if (!ok || tx_q[0] !== 8'h4B) begin errors++; $display("FAIL wait_reply got %h want 4b", tx_q[0]); end
    checks++; if (tx_t[0] !== t1 + 2) begin errors++; $display("FAIL wait_reply_time got %0d want %0d", tx_t[0], t1 + 2); end
    drain();
    // Operands equal to opcode values are data, not commands.
    clear_logs();
    send_byte(8'h57, t);
    send_byte(8'h52, t);
    send_byte(8'h53, t1);
    checks++; if (puf_wait_cyc_o !== 16'h5253) begin errors++; $display("FAIL wait_opval got %h want 5253", puf_wait_cyc_o); end
    drain();
    checks++; if (tx_q.size() !== 1 || tx_q[0] !== 8'h4B) begin errors++; $display("FAIL wait_opval_reply got %0d/%h want 1/4b", tx_q.size(), tx_q[0]); end
    checks++; if (req_t.size() !== 0) begin errors++; $display("FAIL wait_opval_req got %0d want 0", req_t.size()); end
  endtask

  task automatic test_run();
    int t, cb, cd;
    bit ok;
    clear_logs();
    busy_len   = 50;
    puf_busy_i = 1'b1;
    send_byte(8'h52, t);
    repeat (10) @(negedge clk);
    checks++; if (req_t.size() !== 0) begin errors++; $display("FAIL run_req_busy got %0d want 0", req_t.size()); end
    cb = cyc;
    puf_busy_i = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (req_t.size() !== 1) begin errors++; $display("FAIL run_req_count got %0d want 1", req_t.size()); end
    checks++; if (req_t[0] !== cb + 1) begin errors++; $display("FAIL run_req_time got %0d want %0d", req_t[0], cb + 1); end
    cd = cyc;
    puf_q_i = 6'h2A; puf_qn_i = 6'h15; puf_valid_i = 1'b1; puf_done_i = 1'b1;
    @(negedge clk);
    puf_q_i = 6'h00; puf_qn_i = 6'h00; puf_valid_i = 1'b0; puf_done_i = 1'b0;
    wait_tx(2, 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL run_reply got %0d bytes want 2", tx_q.size()); end
    checks++; if (tx_q[0] !== 8'hAA) begin errors++; $display("FAIL run_byte0 got %h want aa", tx_q[0]); end
    checks++; if (tx_q[1] !== 8'h15) begin errors++; $display("FAIL run_byte1 got %h want 15", tx_q[1]); end
    checks++; if (tx_t[0] !== cd + 2) begin errors++; $display("FAIL run_byte0_time got %0d want %0d", tx_t[0], cd + 2); end
    checks++; if (tx_t[1] - tx_t[0] !== 52) begin errors++; $display("FAIL run_spacing got %0d want 52", tx_t[1] - tx_t[0]); end
    drain();
    busy_len = 0;
    checks++; if (tx_q.size() !== 2) begin errors++; $display("FAIL run_count got %0d want 2", tx_q.size()); end
  endtask

  task automatic test_unknown_drop();
    int t, t1;
    bit ok;
    clear_logs();
    busy_force = 1'b1;
    send_byte(8'h00, t);
    send_byte(8'h53, t);
    send_byte(8'h52, t);
    repeat (3) @(negedge clk);
    checks++; if (tx_q.size() !== 0) begin errors++; $display("FAIL unk_held got %0d want 0", tx_q.size()); end
    busy_force = 1'b0;
    wait_tx(1, 20, ok);
    checks++; if (!ok || tx_q[0] !== 8'h3F) begin errors++; $display("FAIL unk_reply got %h want 3f", tx_q[0]); end
    repeat (30) @(negedge clk);
    checks++; if (tx_q.size() !== 1) begin errors++; $display("FAIL drop_extra got %0d want 1", tx_q.size()); end
    checks++; if (req_t.size() !== 0) begin errors++; $display("FAIL drop_req got %0d want 0", req_t.size()); end
    send_byte(8'h53, t);
    send_byte(8'h5A, t1);
    checks++; if (puf_sel_o !== 8'h5A) begin errors++; $display("FAIL drop_then_sel got %h want 5a", puf_sel_o); end
    drain();
  endtask

  task automatic test_reset_mid();
    int t;
    bit ok;
    clear_logs();
    send_byte(8'h57, t);
    send_byte(8'h77, t);
    @(negedge clk);
    uart_rx_data = 8'h88; uart_rx_valid = 1'b1; rst = 1'b1;
    @(negedge clk);
    uart_rx_valid = 1'b0; rst = 1'b0;
    checks++; if (puf_wait_cyc_o !== 16'd100) begin errors++; $display("FAIL rstw_wait got %h want 0064", puf_wait_cyc_o); end
    checks++; if (puf_sel_o !== 8'h00) begin errors++; $display("FAIL rstw_sel got %h want 00", puf_sel_o); end
    checks++; if (seq_tx_data !== 8'h00) begin errors++; $display("FAIL rstw_txd got %h want 00", seq_tx_data); end
    repeat (20) @(negedge clk);
    checks++; if (tx_q.size() !== 0) begin errors++; $display("FAIL rstw_strobe got %0d want 0", tx_q.size()); end
    send_byte(8'h52, t);
    repeat (4) @(negedge clk);
    checks++; if (req_t.size() !== 1) begin errors++; $display("FAIL rstr_req got %0d want 1", req_t.size()); end
    rst = 1'b1; puf_done_i = 1'b1; puf_valid_i = 1'b1; puf_q_i = 6'h3F;
    @(negedge clk);
    rst = 1'b0; puf_done_i = 1'b0; puf_valid_i = 1'b0; puf_q_i = 6'h00;
    checks++; if (seq_tx_valid !== 1'b0 || puf_req_o !== 1'b0) begin errors++; $display("FAIL rstr_outs got %b%b want 00", seq_tx_valid, puf_req_o); end
    repeat (20) @(negedge clk);
    checks++; if (tx_q.size() !== 0) begin errors++; $display("FAIL rstr_strobe got %0d want 0", tx_q.size()); end
    send_byte(8'h00, t);
    wait_tx(1, 20, ok);
    checks++; if (!ok || tx_q[0] !== 8'h3F) begin errors++; $display("FAIL rstr_idle got %h want 3f", tx_q[0]); end
    drain();
  endtask

`ifdef PUF_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int t;
    bit ok;
    clear_logs();
    send_byte(8'h52, t);
    wait_tx(1, 60, ok);
    checks++; if (!ok || tx_q[0] !== 8'h54) begin errors++; $display("FAIL tmo_reply got %h want 54", tx_q[0]); end
    checks++; if (tx_t[0] - req_t[0] < 19 || tx_t[0] - req_t[0] > 24) begin
      errors++; $display("FAIL tmo_time got %0d want 19..24", tx_t[0] - req_t[0]);
    end
    drain();
    checks++; if (tx_q.size() !== 1) begin errors++; $display("FAIL tmo_count got %0d want 1", tx_q.size()); end
    send_byte(8'h53, t);
    send_byte(8'h11, t);
    checks++; if (puf_sel_o !== 8'h11) begin errors++; $display("FAIL tmo_idle got %h want 11", puf_sel_o); end
    drain();
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    uart_rx_data = 8'h00; uart_rx_valid = 1'b0; uart_tx_busy = 1'b0;
    puf_valid_i = 1'b0; puf_done_i = 1'b0; puf_busy_i = 1'b0;
    puf_q_i = 6'h00; puf_qn_i = 6'h00;
    test_reset();
    test_sel();
    test_wait();
    test_run();
    test_unknown_drop();
    test_reset_mid();
`ifdef PUF_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/puf_uart_seq.md
# puf_uart_seq

Command sequencer between the UART receive/transmit path and the PUF core. Decodes single-byte opcodes and operands from the UART receiver and holds the PUF select and wait-cycle configuration. Issues PUF evaluation requests and streams the response bytes back through the UART transmitter using its strobe/busy handshake. Sits at top level in the 100 MHz `clk` domain, driving the PUF core request/select inputs and the UART `i_tx_data`/`i_tx_stb` inputs.

## Interface

- `SEL_W`, 8: PUF select width; equals `seq_dp_width`.
- `WAIT_W`, 16: width of the PUF wait-cycle configuration.
- `WAIT_DEF`, 16'd100: reset value of the wait-cycle register.
- `TIMEOUT_CYC`, 24'd1_000_000: `clk` cycles allowed between request and `puf_done_i`. Used only with `PUF_SEQ_TIMEOUT_EN`.

Ports:

- `clk` in 1: 100 MHz clock, the only clock.
- `rst` in 1: synchronous, active-high reset.
- `uart_rx_data` in 8: received byte.
- `uart_rx_valid` in 1: one-cycle strobe qualifying `uart_rx_data`.
- `uart_tx_busy` in 1: transmitter busy.
- `seq_tx_data` out `SEL_W`: byte to transmit.
- `seq_tx_valid` out 1: one-cycle transmit strobe.
- `puf_req_o` out 1: one-cycle evaluation request.
- `puf_sel_o` out `SEL_W`: PUF select.
- `puf_wait_cyc_o` out `WAIT_W`: settle/wait cycles for the PUF core.
- `puf_valid_i` in 1: PUF result valid.
- `puf_done_i` in 1: PUF evaluation complete.
- `puf_busy_i` in 1: PUF core busy.
- `puf_q_i` in 6: PUF Q outputs.
- `puf_qn_i` in 6: PUF Qn outputs.

## Operation

Opcodes:

- `0x53` 'S': one operand byte follows. Loads `puf_sel_o`, replies `0x4B` 'K'.
- `0x57` 'W': two operand bytes follow, MSB first. Loads `puf_wait_cyc_o`, replies 'K'. The register updates only after the second byte arrives.
- `0x52` 'R': runs one evaluation. Replies with two bytes:
  - byte 0 = `{puf_valid_i, 1'b0, puf_q_i}`
  - byte 1 = `{2'b00, puf_qn_i}`
  - Both are captured in the cycle `puf_done_i` is sampled high.
- Any other byte: replies `0x3F` '?'.

FSM states and transitions:

- IDLE: an opcode strobe goes to ARG (S/W), REQ (R), or SEND ('?').
- ARG: counts operand bytes. After the last byte, loads the register and goes to SEND.
- REQ: waits while `puf_busy_i`=1. With `puf_busy_i`=0, pulses `puf_req_o` one cycle and goes to WAIT.
- WAIT: on `puf_done_i`=1, captures the result and goes to SEND.
- SEND: when `uart_tx_busy`=0, pulses `seq_tx_valid` one cycle with `seq_tx_data` stable, then goes to HOLD.
- HOLD: ignores busy for one guard cycle, then waits for `uart_tx_busy`=0. Returns to SEND if reply bytes remain, otherwise to IDLE.

Rules:

- Receive strobes arriving outside IDLE/ARG are dropped. No buffering.
- Operand bytes are taken verbatim, so an operand equal to an opcode value is not decoded.
- `seq_tx_data` holds its last value between strobes.
- Reset values:
  - all outputs and state are 0, except `puf_wait_cyc_o` = `WAIT_DEF`.
  - FSM = IDLE.
- `rst` mid-command aborts immediately:
  - partial operands are discarded.
  - a pending reply is not sent.
  - `puf_req_o` and `seq_tx_valid` are low in the cycle after `rst`.

## Timing

- Receive strobe to next state: 1 cycle. The register load is visible the cycle after the last operand strobe.
- 'K' reply: `seq_tx_valid` rises 2 cycles after the final byte strobe, provided `uart_tx_busy`=0.
- 'R':
  - `puf_req_o` rises 2 cycles after the opcode strobe when `puf_busy_i`=0.
  - The first reply byte strobes 2 cycles after `puf_done_i` is sampled, provided the transmitter is idle.
- Back-to-back reply bytes are at least 3 cycles apart: strobe, guard, busy check.
- `puf_done_i` coincident with `rst`: reset wins and the result is discarded.

## Configuration

- `PUF_SEQ_TIMEOUT_EN` defined:
  - WAIT runs a 24-bit counter cleared on entry.
  - If it reaches `TIMEOUT_CYC` without `puf_done_i`, the FSM replies the single byte `0x54` 'T' and returns to IDLE.
  - `puf_done_i` in the same cycle as expiry takes priority and produces the normal result reply.
- Undefined: no counter is built and WAIT holds until `puf_done_i`, indefinitely.

## Test plan

- Reset, then check outputs: `puf_sel_o`=0, `puf_wait_cyc_o`=100, `seq_tx_valid`=0, `puf_req_o`=0.
- Send `0x53`, `0xA5` -> `puf_sel_o`=`0xA5` and one strobe with data `0x4B`. Send `0x57`, `0x12`, `0x34` -> `puf_wait_cyc_o`=`0x1234` and reply 'K'.
- Send `0x52` with `puf_busy_i` held high for 10 cycles -> no `puf_req_o` until busy falls, then a one-cycle req. Model done with Q=`0x2A`, Qn=`0x15`, valid=1 -> bytes `0xAA`, `0x15` in order. Hold `uart_tx_busy` for 50 cycles after each strobe to check no overlap.
- Send `0x00` -> reply `0x3F`. Send a byte strobe during SEND -> dropped, and no extra reply.
- With `PUF_SEQ_TIMEOUT_EN`, `TIMEOUT_CYC`=20, and `puf_done_i` never asserted -> 'T' strobed about 22 cycles after req, FSM back in IDLE.
- Assert `rst` during the second operand of 'W' and during WAIT -> registers keep reset values and no strobe appears afterwards.
